spi_master_cfg: RTL and testbench

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 168 ++++++++++++++++
 tb/tb_spi_master_cfg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: configurable SPI master with per-frame cpol/cpha/bit-order
// and clock divider, decoded active-low slave selects.
module spi_master_cfg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EC_W = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [EC_W-1:0]   edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DIV_W-1:0]  div_l;
    logic [SS_W-1:0]   sel_l;
    logic              cpol_l;
    logic              cpha_l;
    logic              lsb_l;

    // Active-low one-hot select; out-of-range index leaves every line high
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (32'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    // Bit that leaves the transmit register next
    function automatic logic tx_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    // Drop the bit just sent
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
    endfunction

    // Insert a received bit so the word ends up in transmit order
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] r, input logic b,
                                                   input logic lsb);
        return lsb ? {b, r[DATA_W-1:1]} : {r[DATA_W-2:0], b};
    endfunction

    logic div_tick;
    logic odd_edge;
    logic sample_edge;

    // Half-period elapsed; edge parity counted 1-based (edge_cnt 0 is edge 1)
    assign div_tick    = (div_cnt == div_l);
    assign odd_edge    = ~edge_cnt[0];
    assign sample_edge = cpha_l ? ~odd_edge : odd_edge;

    // Frame sequencer, divider, shift registers and registered SPI outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            div_l    <= '0;
            sel_l    <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done high means the previous frame just closed; skip that cycle
                    if (start && !done) begin
                        div_l    <= clk_div;
                        sel_l    <= ss_sel;
                        cpol_l   <= cpol;
                        cpha_l   <= cpha;
                        lsb_l    <= lsb_first;
                        sclk     <= cpol;
                        mosi     <= tx_bit(data_in, lsb_first);
                        tx_sh    <= cpha ? data_in : tx_shift(data_in, lsb_first);
                        rx_sh    <= '0;
                        ss_n     <= ss_decode(ss_sel);
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        state   <= XFER;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                XFER: begin
                    if (div_tick) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EC_W'(1);
                        if (sample_edge) begin
                            rx_sh <= rx_shift(rx_sh, miso, lsb_l);
                        end else if (edge_cnt != LAST_EDGE) begin
                            mosi  <= tx_bit(tx_sh, lsb_l);
                            tx_sh <= tx_shift(tx_sh, lsb_l);
                        end
                        if (edge_cnt == LAST_EDGE) begin
                            edge_cnt <= '0;
                            state    <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (div_tick) begin
                        div_cnt  <= '0;
                        ss_n     <= '1;
                        data_out <= rx_sh;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: directed cases plus randomized frames
// against a behavioural slave / frame-timing model.
module tb_spi_master_cfg;

    localparam int unsigned DW  = 8;
    localparam int unsigned NS  = 4;
    localparam int unsigned DW2 = 16;
    localparam int unsigned NS2 = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic [1:0]    ss_sel;
    logic          cpol;
    logic          cpha;
    logic          lsb_first;
    logic [7:0]    clk_div;
    logic          miso;
    logic          sclk;
    logic          mosi;
    logic [NS-1:0] ss_n;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;

    logic           start16;
    logic [DW2-1:0] data_in16;
    logic [7:0]     clk_div16;
    logic           sclk16;
    logic           mosi16;
    logic [NS2-1:0] ss_n16;
    logic [DW2-1:0] data_out16;
    logic           busy16;
    logic           done16;

    int errors = 0;
    int checks = 0;

    // behavioural slave configuration for the current frame
    logic          f_cpha   = 1'b0;
    logic          f_lsb    = 1'b0;
    logic [DW-1:0] f_sword  = '0;
    logic          loopback = 1'b1;
    logic          slave_miso = 1'b0;
    int            sedge = 0;
    logic          prev_busy = 1'b0;
    logic          prev_sclk = 1'b0;

    assign miso = loopback ? mosi : slave_miso;

    spi_master_cfg #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
        .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .data_out(data_out),
        .busy(busy), .done(done)
    );

    spi_master_cfg #(.DATA_W(DW2), .NUM_SS(NS2), .DIV_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .data_in(data_in16), .ss_sel(2'd3),
        .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .clk_div(clk_div16),
        .miso(mosi16), .sclk(sclk16), .mosi(mosi16), .ss_n(ss_n16), .data_out(data_out16),
        .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    // Slave: count SCLK edges of the running frame, present bit k of f_sword
    // before the edge on which the master samples it
    always @(negedge clk) begin
        int nxt;
        int idx;
        nxt = sedge;
        if (!busy) nxt = 0;
        else if (prev_busy && (sclk !== prev_sclk)) nxt = sedge + 1;
        if (!f_cpha) idx = nxt / 2;
        else idx = (nxt == 0) ? -1 : (nxt - 1) / 2;
        if (idx >= 0 && idx < int'(DW))
            slave_miso <= f_sword[f_lsb ? idx : int'(DW) - 1 - idx];
        else
            slave_miso <= 1'b0;
        sedge     <= nxt;
        prev_busy <= busy;
        prev_sclk <= sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS-1:0] exp_ss(input logic [1:0] sel);
        logic [NS-1:0] v;
        v = '1;
        v[sel] = 1'b0;
        return v;
    endfunction

    task automatic set_cfg(input logic [7:0] d, input logic [1:0] sel, input logic pol,
                           input logic pha, input logic lsb, input logic [7:0] div,
                           input logic [7:0] sword, input logic lb);
        data_in = d; ss_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
        f_cpha = pha; f_lsb = lsb; f_sword = sword; loopback = lb;
    endtask

    // Called at the first negedge after acceptance; returns at the done negedge
    task automatic wait_done(input int limit, input logic [NS-1:0] ess, output int n,
                             output int rises, output bit ss_ok, output bit got);
        logic ps;
        n = 1; rises = 0; ss_ok = 1'b1; ps = sclk;
        while (done !== 1'b1 && n < limit) begin
            if (ss_n !== ess) ss_ok = 1'b0;
            @(negedge clk);
            n++;
            if (sclk === 1'b1 && ps === 1'b0) rises++;
            ps = sclk;
        end
        got = (done === 1'b1);
    endtask

    // Full frame with timing, data, select and idle-level checks
    task automatic frame(input logic [7:0] d, input logic [1:0] sel, input logic pol,
                         input logic pha, input logic lsb, input logic [7:0] div,
                         input logic [7:0] sword, input logic lb, input string tag);
        int n, rises, exp_lat;
        bit ss_ok, got;
        exp_lat = (2 * int'(DW) + 2) * (int'(div) + 1);
        @(negedge clk);
        set_cfg(d, sel, pol, pha, lsb, div, sword, lb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(exp_lat + 50, exp_ss(sel), n, rises, ss_ok, got);
        check({tag, "/done"}, 32'(got), 32'd1);
        check({tag, "/latency"}, 32'(n - 1), 32'(exp_lat));
        check({tag, "/data_out"}, 32'(data_out), 32'(lb ? d : sword));
        check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "/sclk_rises"}, 32'(rises), 32'(DW));
        check({tag, "/ss_n_frame"}, 32'(ss_ok), 32'd1);
        check({tag, "/ss_n_idle"}, 32'(ss_n), 32'hF);
        @(negedge clk);
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/sclk_idle"}, 32'(sclk), 32'(pol));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rises, extra, t1, t2, exp_lat;
        bit ss_ok, got;
        logic ps;

        clk = 1'b0; rst = 1'b1; start = 1'b0;
        set_cfg(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        start16 = 1'b0; data_in16 = '0; clk_div16 = '0;
        #3 rst = 1'b0;
        #10;
        check("rst/sclk", 32'(sclk), 32'd0);
        check("rst/mosi", 32'(mosi), 32'd0);
        check("rst/ss_n", 32'(ss_n), 32'hF);
        check("rst/data_out", 32'(data_out), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b1;

        // loopback A5, msb-first, mode 0, fastest divider: 18 cycles, 8 rises
        frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, "lb_a5");

        // every SPI mode against the slave returning 3C, lsb-first, div 3
        for (int m = 0; m < 4; m++)
            frame(8'h81, 2'd1, 1'(m >> 1), 1'(m), 1'b1, 8'd3, 8'h3C, 1'b0, "mode");

        // select lines follow ss_sel frame by frame
        frame(8'h5C, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 8'hE1, 1'b0, "sel2");
        frame(8'h96, 2'd3, 1'b1, 1'b0, 1'b1, 8'd0, 8'h4B, 1'b1, "sel3");

        // start during done cycle ignored, accepted on the following cycle
        @(negedge clk);
        set_cfg(8'h6D, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, exp_ss(2'd0), n, rises, ss_ok, got);
        check("b2b/first_done", 32'(got), 32'd1);
        set_cfg(8'h3B, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'h00, 1'b1);
        start = 1'b1;
        @(negedge clk);
        check("b2b/start_on_done_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        check("b2b/start_after_done_taken", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(100, exp_ss(2'd1), n, rises, ss_ok, got);
        check("b2b/second_done", 32'(got), 32'd1);
        check("b2b/latency", 32'(n - 1), 32'(2 * DW + 2));
        check("b2b/data_out", 32'(data_out), 32'h3B);

        // restart and input changes mid-frame have no effect
        @(negedge clk);
        set_cfg(8'hC3, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        data_in = 8'h18; lsb_first = 1'b1; cpha = 1'b1; clk_div = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, exp_ss(2'd1), n, rises, ss_ok, got);
        check("restart/done", 32'(got), 32'd1);
        check("restart/data_out", 32'(data_out), 32'hC3);
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        check("restart/no_second_frame", 32'(extra), 32'd0);

        // reset at bit 4 aborts the frame immediately
        @(negedge clk);
        set_cfg(8'h77, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort/sclk", 32'(sclk), 32'd0);
        check("abort/mosi", 32'(mosi), 32'd0);
        check("abort/ss_n", 32'(ss_n), 32'hF);
        check("abort/data_out", 32'(data_out), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        rst = 1'b1;
        check("abort/no_done", 32'(extra), 32'd0);
        frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, "after_abort");

        // randomized frames
        for (int k = 0; k < 20; k++)
            frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), "rand");

        // 16-bit instance, maximum divider, out-of-range select
        exp_lat = (2 * int'(DW2) + 2) * 256;
        @(negedge clk);
        data_in16 = 16'hBEEF; clk_div16 = 8'hFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 1; t1 = -1; t2 = -1; ss_ok = 1'b1; ps = sclk16;
        while (done16 !== 1'b1 && n < exp_lat + 600) begin
            if (ss_n16 !== 3'b111) ss_ok = 1'b0;
            @(negedge clk);
            n++;
            if (sclk16 !== ps) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            ps = sclk16;
        end
        check("w16/done", 32'(done16), 32'd1);
        check("w16/latency", 32'(n - 1), 32'(exp_lat));
        check("w16/data_out", 32'(data_out16), 32'hBEEF);
        check("w16/first_edge", 32'(t1 - 1), 32'd512);
        check("w16/half_period", 32'(t2 - t1), 32'd256);
        check("w16/ss_n_out_of_range", 32'(ss_ok), 32'd1);
        check("w16/busy_at_done", 32'(busy16), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
